// File: rtl/seq_factorizer.sv
// seq_factorizer: trial-division prime factorizer built from subtractions only,
// streaming prime factors in non-decreasing order over a valid/ready handshake.
module seq_factorizer #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     number,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     factor,
    output logic                 factor_valid,
    input  logic                 factor_ready,
    output logic [CNT_WIDTH-1:0] factor_count,
    output logic                 is_prime
);
    localparam int W2 = 2 * WIDTH;
    typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, EMIT, EMIT_LAST, DONE} state_t;
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d, d_q, d_d, r_q, r_d, q_q, q_d, factor_q, factor_d;
    logic [W2-1:0]        sq_q, sq_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 busy_q, busy_d, done_q, done_d, valid_q, valid_d, prime_q, prime_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            m_q      <= '0;
            d_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            sq_q     <= '0;
            factor_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            prime_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            d_q      <= d_d;
            r_q      <= r_d;
            q_q      <= q_d;
            sq_q     <= sq_d;
            factor_q <= factor_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            prime_q  <= prime_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        d_d      = d_q;
        r_d      = r_q;
        q_d      = q_q;
        sq_d     = sq_q;
        factor_d = factor_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = done_q;
        valid_d  = valid_q;
        prime_d  = prime_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                m_d     = number;
                d_d     = WIDTH'(2);
                sq_d    = W2'(4);
                count_d = '0;
                done_d  = 1'b0;
                prime_d = 1'b0;
                busy_d  = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                if (m_q < WIDTH'(2)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (sq_q > W2'(m_q)) begin
                    // no divisor up to sqrt(m) remains, so m itself is the last prime
                    factor_d = m_q;
                    valid_d  = 1'b1;
                    state_d  = EMIT_LAST;
                end else begin
                    r_d     = m_q;
                    q_d     = '0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if (r_q >= d_q) begin
                    r_d = r_q - d_q;
                    q_d = q_q + WIDTH'(1);
                end else if (r_q == '0) begin
                    factor_d = d_q;
                    valid_d  = 1'b1;
                    state_d  = EMIT;
                end else begin
                    // (d+1)^2 = d^2 + 2d + 1
                    d_d     = d_q + WIDTH'(1);
                    sq_d    = sq_q + {{(WIDTH-1){1'b0}}, d_q, 1'b1};
                    state_d = CHECK;
                end
            end
            EMIT: if (factor_ready) begin
                m_d     = q_q;
                count_d = count_q + CNT_WIDTH'(1);
                valid_d = 1'b0;
                state_d = CHECK;
            end
            EMIT_LAST: if (factor_ready) begin
                count_d = count_q + CNT_WIDTH'(1);
                prime_d = (count_q == '0);
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy         = busy_q;
    assign done         = done_q;
    assign factor       = factor_q;
    assign factor_valid = valid_q;
    assign factor_count = count_q;
    assign is_prime     = prime_q;
endmodule

// File: tb/tb_seq_factorizer.sv
// tb_seq_factorizer: drives 8-bit and 16-bit factorizers with random numbers, stalls
// and stray starts, comparing the factor streams to a divide-and-modulo reference.
module tb_seq_factorizer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0, ready8 = 1'b0, ready16 = 1'b0;
    logic [7:0]  num8 = '0, fac8;
    logic [15:0] num16 = '0, fac16;
    logic        busy8, done8, val8, prime8, busy16, done16, val16, prime16;
    logic [3:0]  cnt8;
    logic [4:0]  cnt16;
    int          n_checks = 0, n_fail = 0;
    int          exp_q[$];

    always #5 clk = ~clk;

    seq_factorizer #(.WIDTH(8), .CNT_WIDTH(4)) u8 (
        .clk(clk), .reset(reset), .start(start8), .number(num8), .busy(busy8), .done(done8),
        .factor(fac8), .factor_valid(val8), .factor_ready(ready8), .factor_count(cnt8),
        .is_prime(prime8)
    );
    seq_factorizer #(.WIDTH(16), .CNT_WIDTH(5)) u16 (
        .clk(clk), .reset(reset), .start(start16), .number(num16), .busy(busy16), .done(done16),
        .factor(fac16), .factor_valid(val16), .factor_ready(ready16), .factor_count(cnt16),
        .is_prime(prime16)
    );

    function automatic logic [15:0] o_fac(bit w);   return w ? fac16 : {8'b0, fac8}; endfunction
    function automatic logic        o_valid(bit w); return w ? val16 : val8;         endfunction
    function automatic logic        o_done(bit w);  return w ? done16 : done8;       endfunction
    function automatic logic        o_busy(bit w);  return w ? busy16 : busy8;       endfunction
    function automatic logic        o_prime(bit w); return w ? prime16 : prime8;     endfunction
    function automatic logic [4:0]  o_cnt(bit w);   return w ? cnt16 : {1'b0, cnt8}; endfunction

    task automatic drive_start(input bit w, input logic st, input int n);
        if (w) begin start16 = st; num16 = 16'(n); end
        else begin start8 = st; num8 = 8'(n); end
    endtask

    task automatic drive_ready(input bit w, input logic r);
        if (w) ready16 = r; else ready8 = r;
    endtask

    function automatic void factorize(input int n);
        int m = n;
        exp_q.delete();
        if (m < 2) return;
        for (int p = 2; p * p <= m; p++)
            while (m % p == 0) begin exp_q.push_back(p); m = m / p; end
        if (m > 1) exp_q.push_back(m);
    endfunction

    task automatic run_case(input bit w, input int n, input int stall, input bit poke);
        int got[$];
        int cyc = 0, wait_cnt = 0;
        bit timed_out = 0, prev_stall = 0, saw_valid = 0;
        logic [15:0] held = '0;
        factorize(n);
        @(negedge clk);
        drive_start(w, 1'b1, n);
        @(posedge clk);
        #1;
        drive_start(w, 1'b0, $urandom);
        n_checks++;
        if (o_busy(w) !== 1'b1 || o_done(w) !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_start n=%0d: busy=%b done=%b required busy=1 done=0", n, o_busy(w), o_done(w));
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (o_done(w) === 1'b1) break;
            if (cyc > 40000) begin timed_out = 1; break; end
            n_checks++;
            if (o_cnt(w) !== 5'(got.size())) begin
                n_fail++;
                $display("FAIL running_count n=%0d: got %0d required %0d", n, o_cnt(w), got.size());
            end
            if (prev_stall && o_valid(w) !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL valid_drop n=%0d: factor_valid=%b required 1", n, o_valid(w));
            end
            if (o_valid(w) === 1'b1) begin
                saw_valid = 1;
                if (wait_cnt == 0) held = o_fac(w);
                else begin
                    n_checks++;
                    if (o_fac(w) !== held) begin
                        n_fail++;
                        $display("FAIL factor_stable n=%0d: got %0d required %0d", n, o_fac(w), held);
                    end
                end
                if (wait_cnt < stall) begin
                    drive_ready(w, 1'b0);
                    wait_cnt++;
                    prev_stall = 1;
                end else begin
                    drive_ready(w, 1'b1);
                    got.push_back(int'(held));
                    wait_cnt = 0;
                    prev_stall = 0;
                end
            end else begin
                drive_ready(w, 1'($urandom_range(0, 1)));
                prev_stall = 0;
            end
            if (poke) drive_start(w, 1'($urandom_range(0, 1)), $urandom);
        end
        drive_start(w, 1'b0, 0);
        drive_ready(w, 1'b0);
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL timeout n=%0d: done=0 after %0d cycles required done=1", n, cyc);
        end
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL factor_total n=%0d: got %0d factors required %0d", n, got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL factor[%0d] n=%0d: got %0d required %0d", i, n, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (o_cnt(w) !== 5'(exp_q.size())) begin
            n_fail++;
            $display("FAIL factor_count n=%0d: got %0d required %0d", n, o_cnt(w), exp_q.size());
        end
        n_checks++;
        if (o_prime(w) !== 1'(n >= 2 && exp_q.size() == 1)) begin
            n_fail++;
            $display("FAIL is_prime n=%0d: got %b required %b", n, o_prime(w), (n >= 2 && exp_q.size() == 1));
        end
        n_checks++;
        if (o_busy(w) !== 1'b0 || o_valid(w) !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_in_done n=%0d: busy=%b valid=%b required 0 0", n, o_busy(w), o_valid(w));
        end
        if (n < 2) begin
            n_checks++;
            if (cyc != 2 || saw_valid) begin
                n_fail++;
                $display("FAIL trivial_latency n=%0d: done after %0d cycles valid_seen=%b required 2 and 0", n, cyc, saw_valid);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy8, done8, val8, prime8, fac8, cnt8} !== '0) begin
            n_fail++;
            $display("FAIL reset8: got %h required 0", {busy8, done8, val8, prime8, fac8, cnt8});
        end
        n_checks++;
        if ({busy16, done16, val16, prime16, fac16, cnt16} !== '0) begin
            n_fail++;
            $display("FAIL reset16: got %h required 0", {busy16, done16, val16, prime16, fac16, cnt16});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        run_case(0, 12, 0, 0);
        run_case(0, 13, 0, 0);
        run_case(0, 0, 0, 0);
        run_case(0, 1, 0, 0);
        run_case(0, 2, 0, 0);
        run_case(0, 4, 1, 0);
        run_case(0, 128, 0, 0);
    endtask

    task automatic test_stall;
        run_case(0, 255, 20, 0);
        run_case(0, 169, 5, 0);
    endtask

    task automatic test_back_to_back;
        run_case(0, 12, 0, 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (done8 !== 1'b1 || cnt8 !== 4'd3) begin
            n_fail++;
            $display("FAIL done_hold: done=%b count=%0d required 1 3", done8, cnt8);
        end
        run_case(0, 30, 1, 1);
        run_case(0, 97, 0, 1);
    endtask

    task automatic test_random;
        for (int k = 0; k < 12; k++)
            run_case(0, $urandom_range(0, 255), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset_mid;
        bit reached = 0;
        @(negedge clk);
        drive_start(0, 1'b1, 200);
        @(negedge clk);
        drive_start(0, 1'b0, 0);
        for (int c = 0; c < 3000; c++) begin
            if (val8 === 1'b1 && cnt8 === 4'd1) begin reached = 1; break; end
            ready8 = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL reach_second_factor: valid=%b count=%0d required 1 1", val8, cnt8);
        end
        ready8 = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, val8, prime8, fac8, cnt8} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 0", {busy8, done8, val8, prime8, fac8, cnt8});
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy8, done8, val8, cnt8} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h required 0", {busy8, done8, val8, cnt8});
        end
        ready8 = 1'b0;
        reset = 1'b0;
        run_case(0, 7, 0, 0);
    endtask

    task automatic test_width16;
        run_case(1, 1021, 0, 0);
        run_case(1, 771, 2, 0);
        run_case(1, 1024, 0, 1);
        run_case(1, 1, 0, 0);
        for (int k = 0; k < 3; k++)
            run_case(1, $urandom_range(256, 1500), $urandom_range(0, 2), 1);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_back_to_back;
        test_random;
        test_reset_mid;
        test_width16;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
